lc4_rob_commit: RTL and testbench

Four-entry reorder buffer and in-order commit stage for the out-of-order LC4 core. It sits directly downstream of the writeback stage:
- Dispatch allocates an entry per instruction.
- Writeback marks the entry named by `W_rob_index` complete and stores its results.
- Commit retires the head entry once it is complete, driving architectural regfile/NZP updates and freeing the old physical register.

---
 rtl/lc4_rob_commit_if.sv | 59 +++++
 rtl/lc4_rob_commit.sv | 161 ++++++++++++++++
 tb/tb_lc4_rob_commit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_rob_commit_if.sv
// rtl/lc4_rob_commit_if.sv - dispatch/writeback/commit bundle for the LC4 reorder buffer
//
// Purpose: groups every ROB-facing signal. The ROB connects through the
// slave modport; the driving pipeline (or a bench) uses the master modport.
// Groups:
//   D_*  dispatch allocation request, ready and assigned index
//   W_*  writeback completion of a named entry
//   C_*  head-entry commit outputs and mispredict flush
//   rob_count / rob_empty  occupancy
interface lc4_rob_commit_if;
    logic        D_alloc_valid;
    logic [2:0]  D_alloc_ard;
    logic [3:0]  D_alloc_prd;
    logic [3:0]  D_alloc_old_prd;
    logic [15:0] D_alloc_pc;
    logic        D_alloc_ready;
    logic [1:0]  D_rob_index;

    logic        W_valid;
    logic [1:0]  W_rob_index;
    logic        W_regfile_we;
    logic        W_nzp_we;
    logic [2:0]  W_nzp;
    logic [15:0] W_rddata;
    logic [15:0] W_pc_redirect;

    logic        C_valid;
    logic [1:0]  C_rob_index;
    logic [2:0]  C_ard;
    logic [3:0]  C_prd;
    logic [3:0]  C_old_prd;
    logic        C_regfile_we;
    logic        C_nzp_we;
    logic [2:0]  C_nzp;
    logic [15:0] C_rddata;
    logic [15:0] C_next_pc;
    logic        C_flush;

    logic [2:0]  rob_count;
    logic        rob_empty;

    modport slave (
        input  D_alloc_valid, D_alloc_ard, D_alloc_prd, D_alloc_old_prd, D_alloc_pc,
        output D_alloc_ready, D_rob_index,
        input  W_valid, W_rob_index, W_regfile_we, W_nzp_we, W_nzp, W_rddata, W_pc_redirect,
        output C_valid, C_rob_index, C_ard, C_prd, C_old_prd, C_regfile_we, C_nzp_we,
        output C_nzp, C_rddata, C_next_pc, C_flush,
        output rob_count, rob_empty
    );

    modport master (
        output D_alloc_valid, D_alloc_ard, D_alloc_prd, D_alloc_old_prd, D_alloc_pc,
        input  D_alloc_ready, D_rob_index,
        output W_valid, W_rob_index, W_regfile_we, W_nzp_we, W_nzp, W_rddata, W_pc_redirect,
        input  C_valid, C_rob_index, C_ard, C_prd, C_old_prd, C_regfile_we, C_nzp_we,
        input  C_nzp, C_rddata, C_next_pc, C_flush,
        input  rob_count, rob_empty
    );
endinterface

// File: rtl/lc4_rob_commit.sv
// rtl/lc4_rob_commit.sv - four-entry reorder buffer with in-order commit for the LC4 core
//
// Purpose: dispatch allocates at tail, writeback marks an entry done and
// stores its results, commit retires the head once done.
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset
//   rob  lc4_rob_commit_if.slave (D_* allocate, W_* writeback, C_* commit, occupancy)
// Option: define LC4_ROB_FLUSH_EN to flush all younger entries when the
// committing head was mispredicted; otherwise C_flush is tied low.
module lc4_rob_commit (
    input  logic              clk,
    input  logic              rst,
    lc4_rob_commit_if.slave   rob
);
    logic [3:0]       busy_q, busy_d, done_q, done_d;
    logic [3:0]       regfile_we_q, regfile_we_d, nzp_we_q, nzp_we_d;
    logic [3:0][2:0]  ard_q, ard_d, nzp_q, nzp_d;
    logic [3:0][3:0]  prd_q, prd_d, old_prd_q, old_prd_d;
    logic [3:0][15:0] pc_q, pc_d, rddata_q, rddata_d, next_pc_q, next_pc_d;
    logic [1:0]       head_q, head_d, tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic             full, head_live, c_valid, flush, alloc, wb;

`ifdef LC4_ROB_FLUSH_EN
    logic [3:0]       mispred_q, mispred_d;
`else
    logic             unused_pc;
    assign unused_pc = ^pc_q;
`endif

    always_comb begin
        // Full comes from the registered count, so a same-cycle commit never
        // opens a slot for allocation.
        full      = (count_q == 3'd4);
        head_live = busy_q[head_q];
        c_valid   = busy_q[head_q] & done_q[head_q];
`ifdef LC4_ROB_FLUSH_EN
        flush     = c_valid & mispred_q[head_q];
`else
        flush     = 1'b0;
`endif
        alloc     = rob.D_alloc_valid & ~full & ~flush;
        wb        = rob.W_valid & busy_q[rob.W_rob_index] & ~flush;
    end

    always_comb begin
        busy_d       = busy_q;
        done_d       = done_q;
        ard_d        = ard_q;
        prd_d        = prd_q;
        old_prd_d    = old_prd_q;
        pc_d         = pc_q;
        regfile_we_d = regfile_we_q;
        nzp_we_d     = nzp_we_q;
        nzp_d        = nzp_q;
        rddata_d     = rddata_q;
        next_pc_d    = next_pc_q;
`ifdef LC4_ROB_FLUSH_EN
        mispred_d    = mispred_q;
`endif
        head_d       = head_q + {1'b0, c_valid};
        tail_d       = tail_q + {1'b0, alloc};
        count_d      = count_q + {2'b00, alloc} - {2'b00, c_valid};

        if (alloc) begin
            busy_d[tail_q]    = 1'b1;
            done_d[tail_q]    = 1'b0;
            ard_d[tail_q]     = rob.D_alloc_ard;
            prd_d[tail_q]     = rob.D_alloc_prd;
            old_prd_d[tail_q] = rob.D_alloc_old_prd;
            pc_d[tail_q]      = rob.D_alloc_pc;
        end

        if (wb) begin
            done_d[rob.W_rob_index]       = 1'b1;
            regfile_we_d[rob.W_rob_index] = rob.W_regfile_we;
            nzp_we_d[rob.W_rob_index]     = rob.W_nzp_we;
            nzp_d[rob.W_rob_index]        = rob.W_nzp;
            rddata_d[rob.W_rob_index]     = rob.W_rddata;
            next_pc_d[rob.W_rob_index]    = rob.W_pc_redirect;
`ifdef LC4_ROB_FLUSH_EN
            mispred_d[rob.W_rob_index]    = (rob.W_pc_redirect != pc_q[rob.W_rob_index] + 16'd1);
`endif
        end

        if (c_valid) begin
            busy_d[head_q] = 1'b0;
        end

        // The mispredicted head still retires through the C_* outputs this
        // cycle; everything younger is discarded.
        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = 2'd0;
            tail_d  = 2'd0;
            count_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            done_q       <= '0;
            ard_q        <= '0;
            prd_q        <= '0;
            old_prd_q    <= '0;
            pc_q         <= '0;
            regfile_we_q <= '0;
            nzp_we_q     <= '0;
            nzp_q        <= '0;
            rddata_q     <= '0;
            next_pc_q    <= '0;
`ifdef LC4_ROB_FLUSH_EN
            mispred_q    <= '0;
`endif
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            ard_q        <= ard_d;
            prd_q        <= prd_d;
            old_prd_q    <= old_prd_d;
            pc_q         <= pc_d;
            regfile_we_q <= regfile_we_d;
            nzp_we_q     <= nzp_we_d;
            nzp_q        <= nzp_d;
            rddata_q     <= rddata_d;
            next_pc_q    <= next_pc_d;
`ifdef LC4_ROB_FLUSH_EN
            mispred_q    <= mispred_d;
`endif
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Commit data is forced to zero whenever the head slot holds nothing,
    // which covers the empty ROB.
    always_comb begin
        rob.D_alloc_ready = ~full & ~flush;
        rob.D_rob_index   = tail_q;
        rob.C_valid       = c_valid;
        rob.C_flush       = flush;
        rob.C_rob_index   = head_live ? head_q             : 2'd0;
        rob.C_ard         = head_live ? ard_q[head_q]      : 3'd0;
        rob.C_prd         = head_live ? prd_q[head_q]      : 4'd0;
        rob.C_old_prd     = head_live ? old_prd_q[head_q]  : 4'd0;
        rob.C_nzp         = head_live ? nzp_q[head_q]      : 3'd0;
        rob.C_rddata      = head_live ? rddata_q[head_q]   : 16'd0;
        rob.C_next_pc     = head_live ? next_pc_q[head_q]  : 16'd0;
        rob.C_regfile_we  = c_valid & regfile_we_q[head_q];
        rob.C_nzp_we      = c_valid & nzp_we_q[head_q];
        rob.rob_count     = count_q;
        rob.rob_empty     = (count_q == 3'd0);
    end
endmodule

// File: tb/tb_lc4_rob_commit.sv
// tb/tb_lc4_rob_commit.sv - scoreboard bench for lc4_rob_commit
module tb_lc4_rob_commit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc4_rob_commit_if rif ();
    lc4_rob_commit dut (.clk(clk), .rst(rst), .rob(rif.slave));

    typedef struct {
        logic [1:0] idx;
        logic [2:0] ard;
        logic [3:0] prd;
        logic [3:0] old;
    } alloc_t;

    alloc_t      exp_q[$];
    alloc_t      mon_e;
    logic [15:0] m_rddata [4];
    logic [15:0] m_npc    [4];
    logic [2:0]  m_nzp    [4];
    logic        m_rwe    [4];
    logic        m_nwe    [4];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic        exp_flush;
    logic [2:0]  exp_cnt_a, exp_cnt_b;
    logic        exp_empty_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Every commit must be the oldest outstanding allocation, with the
    // results recorded when its writeback was driven.
    always @(negedge clk) begin
        if (mon_en && !rst && rif.C_valid) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("c_index",  rif.C_rob_index,  mon_e.idx);
                check("c_ard",    rif.C_ard,        mon_e.ard);
                check("c_prd",    rif.C_prd,        mon_e.prd);
                check("c_oldprd", rif.C_old_prd,    mon_e.old);
                check("c_rddata", rif.C_rddata,     m_rddata[mon_e.idx]);
                check("c_nzp",    rif.C_nzp,        m_nzp[mon_e.idx]);
                check("c_rf_we",  rif.C_regfile_we, m_rwe[mon_e.idx]);
                check("c_nzp_we", rif.C_nzp_we,     m_nwe[mon_e.idx]);
                check("c_nextpc", rif.C_next_pc,    m_npc[mon_e.idx]);
            end
        end
    end

    task automatic idle_in();
        rif.D_alloc_valid   = 1'b0;
        rif.D_alloc_ard     = 3'd0;
        rif.D_alloc_prd     = 4'd0;
        rif.D_alloc_old_prd = 4'd0;
        rif.D_alloc_pc      = 16'd0;
        rif.W_valid         = 1'b0;
        rif.W_rob_index     = 2'd0;
        rif.W_regfile_we    = 1'b0;
        rif.W_nzp_we        = 1'b0;
        rif.W_nzp           = 3'd0;
        rif.W_rddata        = 16'd0;
        rif.W_pc_redirect   = 16'd0;
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic set_alloc(input logic [2:0] ard, input logic [3:0] prd,
                             input logic [3:0] old, input logic [15:0] pc);
        rif.D_alloc_valid   = 1'b1;
        rif.D_alloc_ard     = ard;
        rif.D_alloc_prd     = prd;
        rif.D_alloc_old_prd = old;
        rif.D_alloc_pc      = pc;
    endtask

    task automatic alloc_cyc(input logic [1:0] idx, input logic [2:0] ard, input logic [3:0] prd,
                             input logic [3:0] old, input logic [15:0] pc);
        alloc_t e;
        set_alloc(ard, prd, old, pc);
        @(negedge clk);
        check("alloc_ready", rif.D_alloc_ready, 1);
        check("alloc_idx",   rif.D_rob_index,   idx);
        e.idx = idx; e.ard = ard; e.prd = prd; e.old = old;
        exp_q.push_back(e);
        cyc_end();
    endtask

    task automatic wb_set(input logic [1:0] idx, input logic [15:0] data, input logic [2:0] nzp,
                          input logic rwe, input logic nwe, input logic [15:0] npc);
        rif.W_valid       = 1'b1;
        rif.W_rob_index   = idx;
        rif.W_rddata      = data;
        rif.W_nzp         = nzp;
        rif.W_regfile_we  = rwe;
        rif.W_nzp_we      = nwe;
        rif.W_pc_redirect = npc;
        m_rddata[idx] = data;
        m_nzp[idx]    = nzp;
        m_rwe[idx]    = rwe;
        m_nwe[idx]    = nwe;
        m_npc[idx]    = npc;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},  rif.D_alloc_ready, 1);
        check({tag, "_didx"},   rif.D_rob_index,   0);
        check({tag, "_cvalid"}, rif.C_valid,       0);
        check({tag, "_flush"},  rif.C_flush,       0);
        check({tag, "_cidx"},   rif.C_rob_index,   0);
        check({tag, "_ard"},    rif.C_ard,         0);
        check({tag, "_prd"},    rif.C_prd,         0);
        check({tag, "_oldprd"}, rif.C_old_prd,     0);
        check({tag, "_rfwe"},   rif.C_regfile_we,  0);
        check({tag, "_nzpwe"},  rif.C_nzp_we,      0);
        check({tag, "_nzp"},    rif.C_nzp,         0);
        check({tag, "_rddata"}, rif.C_rddata,      0);
        check({tag, "_nextpc"}, rif.C_next_pc,     0);
        check({tag, "_count"},  rif.rob_count,     0);
        check({tag, "_empty"},  rif.rob_empty,     1);
    endtask

    initial begin
`ifdef LC4_ROB_FLUSH_EN
        exp_flush = 1'b1; exp_cnt_a = 3'd0; exp_empty_a = 1'b1; exp_cnt_b = 3'd1;
`else
        exp_flush = 1'b0; exp_cnt_a = 3'd3; exp_empty_a = 1'b0; exp_cnt_b = 3'd4;
`endif
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Fill the ROB: indices 0..3, PCs 0x10..0x13.
        alloc_cyc(2'd0, 3'd5, 4'd9,  4'd3, 16'h0010);
        alloc_cyc(2'd1, 3'd1, 4'd10, 4'd1, 16'h0011);
        alloc_cyc(2'd2, 3'd2, 4'd11, 4'd2, 16'h0012);
        alloc_cyc(2'd3, 3'd3, 4'd12, 4'd4, 16'h0013);

        // Full and head not done: allocation refused.
        set_alloc(3'd7, 4'd15, 4'd7, 16'h0099);
        @(negedge clk);
        check("full_ready", rif.D_alloc_ready, 0);
        check("full_count", rif.rob_count,     4);
        check("full_empty", rif.rob_empty,     0);
        check("full_cv",    rif.C_valid,       0);
        cyc_end();
        @(negedge clk);
        check("full_hold_count", rif.rob_count, 4);

        // Out-of-order completion: 2 then 0.
        wb_set(2'd2, 16'h2222, 3'b001, 1'b1, 1'b1, 16'h0013);
        @(negedge clk);
        check("wb2_no_commit", rif.C_valid, 0);
        cyc_end();
        wb_set(2'd0, 16'h8001, 3'b100, 1'b1, 1'b0, 16'h0011);
        @(negedge clk);
        check("wb0_no_bypass", rif.C_valid, 0);
        cyc_end();
        @(negedge clk);
        check("idx0_commit", rif.C_valid, 1);
        cyc_end();
        @(negedge clk);
        check("idx1_blocks", rif.C_valid,   0);
        check("count_3",     rif.rob_count, 3);
        cyc_end();
        wb_set(2'd1, 16'h1111, 3'b010, 1'b0, 1'b1, 16'h0012);
        @(negedge clk);
        check("wb1_no_bypass", rif.C_valid, 0);
        cyc_end();
        @(negedge clk);
        check("idx1_commit", rif.C_valid, 1);
        cyc_end();
        @(negedge clk);
        check("idx2_commit", rif.C_valid, 1);
        cyc_end();
        @(negedge clk);
        check("idx3_waits", rif.C_valid,   0);
        check("count_1",    rif.rob_count, 1);
        cyc_end();
        wb_set(2'd3, 16'h3333, 3'b001, 1'b1, 1'b1, 16'h0014);
        @(negedge clk);
        cyc_end();
        @(negedge clk);
        check("idx3_commit", rif.C_valid, 1);
        cyc_end();
        @(negedge clk);
        check("drain_count", rif.rob_count, 0);
        check("drain_empty", rif.rob_empty, 1);
        check("drain_cv",    rif.C_valid,   0);
        check("drain_rddata", rif.C_rddata, 0);

        // Second fill; tail wraps back to 0 when full.
        cyc_end();
        alloc_cyc(2'd0, 3'd6, 4'd13, 4'd5, 16'h0020);
        alloc_cyc(2'd1, 3'd1, 4'd14, 4'd6, 16'h0021);
        alloc_cyc(2'd2, 3'd2, 4'd15, 4'd7, 16'h0022);
        alloc_cyc(2'd3, 3'd4, 4'd8,  4'd0, 16'h0023);
        wb_set(2'd0, 16'h4444, 3'b010, 1'b1, 1'b1, 16'h0040);
        @(negedge clk);
        check("wb_mp_no_bypass", rif.C_valid, 0);
        cyc_end();

        // Full, head done (mispredicted), dispatch requesting.
        set_alloc(3'd7, 4'd1, 4'd2, 16'h0024);
        @(negedge clk);
        check("fc_cvalid", rif.C_valid,       1);
        check("fc_ready",  rif.D_alloc_ready, 0);
        check("fc_count",  rif.rob_count,     4);
        check("fc_flush",  rif.C_flush,       exp_flush);
        check("fc_nextpc", rif.C_next_pc,     16'h0040);
        @(posedge clk);
        #1;
`ifdef LC4_ROB_FLUSH_EN
        exp_q.delete();
`endif
        @(negedge clk);
        check("after_count", rif.rob_count,     exp_cnt_a);
        check("after_empty", rif.rob_empty,     exp_empty_a);
        check("after_ready", rif.D_alloc_ready, 1);
        check("after_tail",  rif.D_rob_index,   0);
        begin
            alloc_t e;
            e.idx = 2'd0; e.ard = 3'd7; e.prd = 4'd1; e.old = 4'd2;
            exp_q.push_back(e);
        end
        cyc_end();
        @(negedge clk);
        check("wrap_count", rif.rob_count, exp_cnt_b);
        cyc_end();

        // Bring occupancy to three live entries, then reset.
`ifdef LC4_ROB_FLUSH_EN
        alloc_cyc(2'd1, 3'd3, 4'd3, 4'd4, 16'h0025);
        alloc_cyc(2'd2, 3'd3, 4'd5, 4'd6, 16'h0026);
`else
        wb_set(2'd1, 16'h5555, 3'b001, 1'b1, 1'b1, 16'h0022);
        @(negedge clk);
        cyc_end();
        @(negedge clk);
        check("pre_rst_commit", rif.C_valid, 1);
        cyc_end();
`endif
        @(negedge clk);
        check("pre_rst_count", rif.rob_count, 3);
        cyc_end();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_reset("rst1");
        rst = 1'b0;
        // Writeback to a now-empty index must be ignored.
        rif.W_valid       = 1'b1;
        rif.W_rob_index   = 2'd1;
        rif.W_rddata      = 16'hdead;
        rif.W_regfile_we  = 1'b1;
        rif.W_pc_redirect = 16'h0077;
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        check("ign_cvalid", rif.C_valid,   0);
        check("ign_count",  rif.rob_count, 0);
        check("ign_empty",  rif.rob_empty, 1);
        check("ign_rddata", rif.C_rddata,  0);
        cyc_end();
        @(negedge clk);
        check("ign_cvalid2", rif.C_valid,   0);
        check("leftover",    exp_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
